// File: rtl/cmac_op_sequencer.sv
// CMAC per-layer operation sequencer.
// Arms on reg2dp_op_en and tracks shadow weight loads per MAC cell. Issues the
// shadow->active swap at each stripe start and counts stripes. After layer end it
// waits for the MAC pipeline to drain, then pulses dp2reg_done.
module cmac_op_sequencer #(
  parameter int unsigned ATOMK_HALF = 8,
  parameter int unsigned PIPE_LAT   = 7,
  parameter int unsigned STRIPE_W   = 16
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic                  reg2dp_op_en,
  input  logic                  sc2mac_dat_pvld,
  input  logic [8:0]            sc2mac_dat_pd,
  input  logic                  sc2mac_wt_pvld,
  input  logic [ATOMK_HALF-1:0] sc2mac_wt_sel,
  output logic                  cfg_reg_en,
  output logic                  wt_swap,
  output logic [ATOMK_HALF-1:0] wt_swap_mask,
  output logic [STRIPE_W-1:0]   stripe_cnt,
  output logic                  busy,
  output logic                  dp2reg_done,
  output logic                  err_wt_partial,
  output logic                  err_dat_drain
);

  localparam int unsigned DRAIN_W = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                r_state;
  logic [DRAIN_W-1:0]    r_drain_cnt;
  logic [ATOMK_HALF-1:0] r_shadow_mask;
  logic                  r_cfg_reg_en;
  logic                  r_wt_swap;
  logic [ATOMK_HALF-1:0] r_wt_swap_mask;
  logic [STRIPE_W-1:0]   r_stripe_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err_wt_partial;
  logic                  r_err_dat_drain;

  logic w_stripe_st;
  logic w_stripe_end;
  logic w_layer_end;
  logic w_swap;
  logic w_partial;
  logic w_unused_pd;

  // Beat flag decode; bits [4:0] and channel_end carry no sequencing meaning here.
  assign w_stripe_st  = sc2mac_dat_pvld & sc2mac_dat_pd[5];
  assign w_stripe_end = sc2mac_dat_pvld & sc2mac_dat_pd[6];
  assign w_layer_end  = sc2mac_dat_pvld & sc2mac_dat_pd[8];
  assign w_swap       = w_stripe_st & (|r_shadow_mask);
  assign w_partial    = (|r_shadow_mask) & ~(&r_shadow_mask);
  assign w_unused_pd  = ^{sc2mac_dat_pd[4:0], sc2mac_dat_pd[7]};

  // Layer FSM with all outputs registered.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_state          <= StIdle;
      r_drain_cnt      <= '0;
      r_shadow_mask    <= '0;
      r_cfg_reg_en     <= 1'b0;
      r_wt_swap        <= 1'b0;
      r_wt_swap_mask   <= '0;
      r_stripe_cnt     <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_err_wt_partial <= 1'b0;
      r_err_dat_drain  <= 1'b0;
    end else begin
      r_cfg_reg_en   <= 1'b0;
      r_wt_swap      <= 1'b0;
      r_wt_swap_mask <= '0;
      r_done         <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (reg2dp_op_en) begin
            r_state          <= StRun;
            r_cfg_reg_en     <= 1'b1;
            r_busy           <= 1'b1;
            r_shadow_mask    <= '0;
            r_stripe_cnt     <= '0;
            r_err_wt_partial <= 1'b0;
            r_err_dat_drain  <= 1'b0;
          end
        end
        StRun: begin
          if (!reg2dp_op_en && !w_layer_end) begin
            // Abort: drop any half-loaded shadow, keep count and error history.
            r_state       <= StIdle;
            r_busy        <= 1'b0;
            r_shadow_mask <= '0;
          end else begin
            if (w_swap) begin
              r_wt_swap      <= 1'b1;
              r_wt_swap_mask <= r_shadow_mask;
              // A same-cycle weight beat belongs to the next stripe's shadow.
              r_shadow_mask  <= sc2mac_wt_pvld ? sc2mac_wt_sel : '0;
              if (w_partial) r_err_wt_partial <= 1'b1;
            end else if (sc2mac_wt_pvld) begin
              r_shadow_mask <= r_shadow_mask | sc2mac_wt_sel;
            end
            if (w_stripe_end) r_stripe_cnt <= r_stripe_cnt + 1'b1;
            if (w_layer_end) begin
              r_state     <= StDrain;
              r_drain_cnt <= DRAIN_W'(PIPE_LAT);
            end
          end
        end
        StDrain: begin
          if (sc2mac_dat_pvld) r_err_dat_drain <= 1'b1;
          if (sc2mac_wt_pvld) r_shadow_mask <= r_shadow_mask | sc2mac_wt_sel;
          r_drain_cnt <= r_drain_cnt - 1'b1;
          if (r_drain_cnt == DRAIN_W'(1)) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          if (sc2mac_dat_pvld) r_err_dat_drain <= 1'b1;
          if (sc2mac_wt_pvld) r_shadow_mask <= r_shadow_mask | sc2mac_wt_sel;
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cfg_reg_en     = r_cfg_reg_en;
  assign wt_swap        = r_wt_swap;
  assign wt_swap_mask   = r_wt_swap_mask;
  assign stripe_cnt     = r_stripe_cnt;
  assign busy           = r_busy;
  assign dp2reg_done    = r_done;
  assign err_wt_partial = r_err_wt_partial;
  assign err_dat_drain  = r_err_dat_drain;

endmodule

// File: tb/tb_cmac_op_sequencer.sv
// Bench for cmac_op_sequencer: directed stimulus pushes expected pulse events
// (kind, cycle, mask) into a queue; a negedge monitor pops and compares them.
module tb_cmac_op_sequencer;

  localparam logic [8:0] ST = 9'h020;
  localparam logic [8:0] SE = 9'h040;
  localparam logic [8:0] CE = 9'h080;
  localparam logic [8:0] LE = 9'h100;

  localparam int KCfg  = 0;
  localparam int KSwap = 1;
  localparam int KDone = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_en;
  logic        dat_pvld;
  logic [8:0]  dat_pd;
  logic        wt_pvld;
  logic [7:0]  wt_sel;
  logic        cfg_reg_en;
  logic        wt_swap;
  logic [7:0]  wt_swap_mask;
  logic [15:0] stripe_cnt;
  logic        busy;
  logic        dp2reg_done;
  logic        err_wt_partial;
  logic        err_dat_drain;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] mask;
  } evt_t;

  evt_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   t_le;

  cmac_op_sequencer #(
    .ATOMK_HALF(8),
    .PIPE_LAT  (7),
    .STRIPE_W  (16)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .reg2dp_op_en   (op_en),
    .sc2mac_dat_pvld(dat_pvld),
    .sc2mac_dat_pd  (dat_pd),
    .sc2mac_wt_pvld (wt_pvld),
    .sc2mac_wt_sel  (wt_sel),
    .cfg_reg_en     (cfg_reg_en),
    .wt_swap        (wt_swap),
    .wt_swap_mask   (wt_swap_mask),
    .stripe_cnt     (stripe_cnt),
    .busy           (busy),
    .dp2reg_done    (dp2reg_done),
    .err_wt_partial (err_wt_partial),
    .err_dat_drain  (err_dat_drain)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endfunction

  function automatic void push(input int kind, input int at, input logic [7:0] mask);
    evt_t e;
    e.kind = kind;
    e.cyc  = at;
    e.mask = mask;
    exp_q.push_back(e);
  endfunction

  function automatic void check_evt(input int kind, input logic [7:0] mask);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pulse: kind %0d mask 0x%0h at cycle %0d, none expected",
               kind, mask, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.mask != mask) begin
        errors++;
        $display("FAIL pulse: got kind %0d cycle %0d mask 0x%0h expected kind %0d cycle %0d mask 0x%0h",
                 kind, cyc, mask, e.kind, e.cyc, e.mask);
      end
    end
  endfunction

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_reg_en) check_evt(KCfg, 8'h00);
      if (wt_swap) check_evt(KSwap, wt_swap_mask);
      if (dp2reg_done) check_evt(KDone, 8'h00);
      if (!wt_swap) chk("swap_mask_idle_zero", int'(wt_swap_mask), 0);
    end
  end

  // Drive one cycle of inputs just after the rising edge.
  task automatic step(input logic en, input logic dv, input logic [8:0] pd,
                      input logic wv, input logic [7:0] sel);
    @(posedge clk);
    #1;
    op_en    = en;
    dat_pvld = dv;
    dat_pd   = pd;
    wt_pvld  = wv;
    wt_sel   = sel;
  endtask

  initial begin
    rst      = 1'b1;
    op_en    = 1'b0;
    dat_pvld = 1'b0;
    dat_pd   = '0;
    wt_pvld  = 1'b0;
    wt_sel   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_stripe_cnt", int'(stripe_cnt), 0);
    chk("rst_err_wt_partial", int'(err_wt_partial), 0);
    chk("rst_err_dat_drain", int'(err_dat_drain), 0);
    chk("rst_done", int'(dp2reg_done), 0);
    chk("rst_cfg", int'(cfg_reg_en), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Arm: cfg pulse in the first RUN cycle.
    step(1, 0, 9'h0, 0, 8'h00);
    push(KCfg, cyc + 1, 8'h00);
    @(negedge clk) chk("busy_before_arm", int'(busy), 0);

    // Full shadow load across two beats, then swap.
    step(1, 0, 9'h0, 1, 8'h0F);
    @(negedge clk) chk("busy_after_arm", int'(busy), 1);
    step(1, 0, 9'h0, 1, 8'hF0);
    step(1, 1, ST, 0, 8'h00);
    push(KSwap, cyc + 1, 8'hFF);
    step(1, 0, 9'h0, 0, 8'h00);
    step(1, 0, 9'h0, 0, 8'h00);
    @(negedge clk) chk("err_wt_partial_full", int'(err_wt_partial), 0);

    // Partial shadow still swaps, flags the error.
    step(1, 0, 9'h0, 1, 8'h03);
    step(1, 1, ST, 0, 8'h00);
    push(KSwap, cyc + 1, 8'h03);
    step(1, 0, 9'h0, 0, 8'h00);
    step(1, 0, 9'h0, 0, 8'h00);
    @(negedge clk) chk("err_wt_partial_set", int'(err_wt_partial), 1);

    // Same-cycle weight and swap: old mask swaps, new select seeds the shadow.
    step(1, 0, 9'h0, 1, 8'h01);
    step(1, 1, ST, 1, 8'h80);
    push(KSwap, cyc + 1, 8'h01);
    step(1, 1, ST, 0, 8'h00);
    push(KSwap, cyc + 1, 8'h80);
    // Stripe start with empty shadow: no swap.
    step(1, 1, ST, 0, 8'h00);

    // Five stripe_end beats, the last one also ends the layer.
    for (int i = 0; i < 4; i++) step(1, 1, SE, 0, 8'h00);
    step(1, 1, SE | CE | LE, 0, 8'h00);
    t_le = cyc;
    push(KDone, t_le + 8, 8'h00);
    step(1, 0, 9'h0, 0, 8'h00);
    @(negedge clk) begin
      chk("stripe_cnt_5", int'(stripe_cnt), 5);
      chk("busy_drain", int'(busy), 1);
    end
    // Data in DRAIN flags an error; op_en drop is ignored; weights preload.
    step(0, 1, 9'h0, 1, 8'h0C);
    step(0, 0, 9'h0, 0, 8'h00);
    @(negedge clk) chk("err_dat_drain_set", int'(err_dat_drain), 1);
    repeat (8) step(0, 0, 9'h0, 0, 8'h00);
    @(negedge clk) begin
      chk("busy_after_done", int'(busy), 0);
      chk("err_wt_partial_sticky", int'(err_wt_partial), 1);
      chk("stripe_cnt_hold_idle", int'(stripe_cnt), 5);
    end

    // Re-arm clears count and sticky errors.
    step(1, 0, 9'h0, 0, 8'h00);
    push(KCfg, cyc + 1, 8'h00);
    step(1, 0, 9'h0, 0, 8'h00);
    @(negedge clk) begin
      chk("rearm_err_wt_partial", int'(err_wt_partial), 0);
      chk("rearm_err_dat_drain", int'(err_dat_drain), 0);
      chk("rearm_stripe_cnt", int'(stripe_cnt), 0);
    end

    // Abort mid-RUN: back to IDLE, no done, count held.
    step(1, 1, SE, 1, 8'h11);
    step(0, 0, 9'h0, 0, 8'h00);
    step(0, 0, 9'h0, 0, 8'h00);
    @(negedge clk) begin
      chk("busy_abort", int'(busy), 0);
      chk("stripe_cnt_hold_abort", int'(stripe_cnt), 1);
    end
    repeat (3) step(0, 0, 9'h0, 0, 8'h00);

    // Back-to-back layers with op_en held high through done.
    step(1, 0, 9'h0, 0, 8'h00);
    push(KCfg, cyc + 1, 8'h00);
    step(1, 0, 9'h0, 0, 8'h00);
    step(1, 1, LE, 0, 8'h00);
    t_le = cyc;
    push(KDone, t_le + 8, 8'h00);
    push(KCfg, t_le + 10, 8'h00);
    repeat (12) step(1, 0, 9'h0, 0, 8'h00);
    @(negedge clk) chk("busy_second_layer", int'(busy), 1);
    step(0, 0, 9'h0, 0, 8'h00);
    step(0, 0, 9'h0, 0, 8'h00);
    @(negedge clk) chk("busy_abort2", int'(busy), 0);

    // Reset asserted during DRAIN: immediate return, no done.
    step(1, 0, 9'h0, 0, 8'h00);
    push(KCfg, cyc + 1, 8'h00);
    step(1, 0, 9'h0, 0, 8'h00);
    step(1, 1, SE | LE, 0, 8'h00);
    step(0, 0, 9'h0, 0, 8'h00);
    step(0, 0, 9'h0, 0, 8'h00);
    #1 rst = 1'b1;
    @(negedge clk) begin
      chk("busy_async_rst", int'(busy), 0);
      chk("stripe_cnt_async_rst", int'(stripe_cnt), 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) step(0, 0, 9'h0, 0, 8'h00);

    chk("expect_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
